// File: rtl/tnoc_output_switch.sv
// rtl/tnoc_output_switch.sv - per-output-port round-robin switch with packet lock and one-entry output stage
module tnoc_output_switch #(
    parameter int FLIT_WIDTH = 64,
    parameter int PORTS      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            i_request,
    output logic [PORTS-1:0]            o_grant,
    output logic                        o_free,
    input  logic [PORTS-1:0]            i_valid,
    output logic [PORTS-1:0]            o_ready,
    input  logic [PORTS*FLIT_WIDTH-1:0] i_data,
    input  logic [PORTS-1:0]            i_tail,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [FLIT_WIDTH-1:0]       o_data,
    output logic                        o_tail
);

    localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   g_idx;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic               stage_can_accept;
    logic               transfer;
    logic [FLIT_WIDTH-1:0] sel_data;
    logic               sel_tail;

    assign stage_can_accept = !o_valid || i_ready;
    assign o_ready          = (state == BUSY && stage_can_accept) ? o_grant : '0;
    assign o_free           = (state == IDLE);
    assign transfer         = |(i_valid & o_ready);

    // Scan from the priority pointer upward, wrapping, and take the first requester.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= PORTS) begin
                idx = idx - PORTS;
            end
            if (!win_found && i_request[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    // Grant is one-hot, so an OR of masked port lanes is the payload mux.
    always_comb begin
        sel_data = '0;
        sel_tail = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (o_grant[p]) begin
                sel_data = sel_data | i_data[p*FLIT_WIDTH +: FLIT_WIDTH];
                sel_tail = sel_tail | i_tail[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            g_idx   <= '0;
            o_grant <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_tail  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state   <= BUSY;
                        g_idx   <= win_idx;
                        o_grant <= PORTS'(1) << win_idx;
                    end
                end
                BUSY: begin
                    if (transfer && sel_tail) begin
                        state   <= IDLE;
                        o_grant <= '0;
                        ptr     <= (g_idx == IDX_W'(PORTS-1)) ? '0 : g_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A load in the same cycle as a drain simply overwrites the stage.
            if (transfer) begin
                o_valid <= 1'b1;
                o_data  <= sel_data;
                o_tail  <= sel_tail;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
